// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-drive and response bundle of the ALU op sequencer; slave = sequencer, master = front end + ALU.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [IW-1:0]    cmd_dst;
  logic [IW-1:0]    cmd_src;
  logic             cmd_use_imm;
  logic [WIDTH-1:0] cmd_imm;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_s;
  logic [WIDTH-1:0] alu_f;
  logic             alu_zero;
  logic             alu_overflow;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_ovf;
  logic             rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_use_imm, cmd_imm,
    input  alu_f, alu_zero, alu_overflow,
    input  rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_s,
    output rsp_valid, rsp_data, rsp_zero, rsp_ovf, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_use_imm, cmd_imm,
    output alu_f, alu_zero, alu_overflow,
    output rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_s,
    input  rsp_valid, rsp_data, rsp_zero, rsp_ovf, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives an external combinational ALU from a register bank; response valid 2 edges after accept.
// One command in flight, cmd_ready only in IDLE; response held until rsp_ready. ALU_SEQ_LOCAL_FLAGS_EN: local flags.
module alu_op_sequencer #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);
  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] bank [NREGS];
  logic [IW-1:0]    dst_q;
  logic             rsvd_q;
  logic             accept;
  logic             done;
  logic             f_zero;
  logic             f_ovf;

  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign done   = bus.rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
  end

`ifdef ALU_SEQ_LOCAL_FLAGS_EN
  // Overflow is judged on the sign bits of the registered operands and the settled result.
  always_comb begin
    f_zero = (bus.alu_f == '0);
    f_ovf  = 1'b0;
    case (bus.alu_s)
      4'b0010: f_ovf = (bus.alu_a[WIDTH-1] == bus.alu_b[WIDTH-1]) &&
                       (bus.alu_f[WIDTH-1] != bus.alu_a[WIDTH-1]);
      4'b0011: f_ovf = (bus.alu_a[WIDTH-1] != bus.alu_b[WIDTH-1]) &&
                       (bus.alu_f[WIDTH-1] != bus.alu_a[WIDTH-1]);
      4'b0001: f_ovf = (bus.alu_a == {1'b0, {(WIDTH-1){1'b1}}});
      4'b0100: f_ovf = (bus.alu_a == {1'b1, {(WIDTH-1){1'b0}}});
      default: f_ovf = 1'b0;
    endcase
  end
`else
  assign f_zero = bus.alu_zero;
  assign f_ovf  = bus.alu_overflow;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) bank[i] <= '0;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_s    <= 4'b0000;
      bus.rsp_data <= '0;
      bus.rsp_zero <= 1'b0;
      bus.rsp_ovf  <= 1'b0;
      bus.rsp_err  <= 1'b0;
      dst_q        <= '0;
      rsvd_q       <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        // Both operands read the bank before any writeback, so dst==src sees the old value.
        bus.alu_a <= bank[bus.cmd_dst];
        bus.alu_b <= bus.cmd_use_imm ? bus.cmd_imm : bank[bus.cmd_src];
        bus.alu_s <= bus.cmd_op;
        dst_q     <= bus.cmd_dst;
        rsvd_q    <= (bus.cmd_op >= 4'b1100);
      end
      if (state == EXEC) begin
        if (rsvd_q) begin
          bus.rsp_data <= '0;
          bus.rsp_zero <= 1'b0;
          bus.rsp_ovf  <= 1'b0;
          bus.rsp_err  <= 1'b1;
        end else begin
          bank[dst_q]  <= bus.alu_f;
          bus.rsp_data <= bus.alu_f;
          bus.rsp_zero <= f_zero;
          bus.rsp_ovf  <= f_ovf;
          bus.rsp_err  <= 1'b0;
        end
      end
    end
  end
endmodule
